sw_input_periph: RTL and testbench
==================================

SW_INPUT_PERIPH -- requirements
Module: sw_input_periph

Interface
REQ-001 Parameter DB_CYCLES, default 16: the synchronized switch vector must hold a value for this many consecutive cycles before it is accepted; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the debounce counter; 2^CNT_W SHALL be >= DB_CYCLES.
REQ-003 Port i_clk, input, 1: single clock; all state SHALL be on its rising edge.
REQ-004 Port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port i_io_sw, input, 32: raw board switch vector, asynchronous to i_clk.
REQ-006 Port i_sel, input, 1: LSU selects this peripheral during the current cycle.
REQ-007 Port i_we, input, 1: write strobe, qualified by i_sel.
REQ-008 Port i_addr, input, 4: byte offset; only 0x0, 0x4, 0x8 and 0xC are decoded, and i_addr[1:0] is ignored.
REQ-009 Port i_wdata, input, 32: LSU store data.
REQ-010 Port o_rdata, output, 32: read data, combinational from i_sel and i_addr.
REQ-011 Port o_irq, output, 1: level interrupt request.
REQ-012 Port o_sw_stable, output, 32: debounced switch vector, for the top-level debug path.

Function
REQ-013 Each bit of i_io_sw SHALL pass through a two-flop synchronizer (sync1 to sync2) before any other use.
REQ-014 The debounce FSM SHALL have two states, IDLE and SETTLE, with a candidate register cand and a counter cnt.
REQ-015 In IDLE, if sync2 != stable, the FSM SHALL load cand <= sync2 and cnt <= 1, then go to SETTLE; otherwise it stays in IDLE.
REQ-016 In SETTLE, if sync2 != cand, the FSM SHALL load cand <= sync2 and cnt <= 1, and remain in SETTLE (restart).
REQ-017 In SETTLE, if sync2 == cand and cnt == DB_CYCLES-1, the FSM SHALL load stable <= cand and return to IDLE; otherwise cnt <= cnt+1.
REQ-018 In SETTLE, if sync2 returns to stable before acceptance, the FSM SHALL still restart per REQ-016, then accept the unchanged value with no change flags set.
REQ-019 Total latency from an i_io_sw change to the o_sw_stable update SHALL be 2 synchronizer cycles plus DB_CYCLES cycles.
REQ-020 On acceptance, status SHALL be set to status | (stable ^ cand) in the same edge that stable updates.
REQ-021 The register map SHALL be:
  - 0x0 SW, RO: stable
  - 0x4 STATUS, W1C: change flags
  - 0x8 MASK, RW: interrupt enable
  - 0xC INFO, RO: {state bit, 15'b0, DB_CYCLES[15:0]}
REQ-022 A write (i_sel && i_we) to 0x4 SHALL clear the status bits where i_wdata is 1.
REQ-023 A write to 0x8 SHALL load mask <= i_wdata.
REQ-024 Writes to 0x0 and 0xC SHALL be ignored.
REQ-025 A W1C clear and a change set on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-026 o_rdata SHALL be 32'h0 when i_sel is 0 or when i_we is 1.
REQ-027 A read SHALL have no side effects.
REQ-028 o_irq SHALL equal |(status & mask), combinational.

Reset
REQ-029 While i_rst_n is low: sync1, sync2, cand, stable, status, mask, cnt = 0; state = IDLE; o_sw_stable = 0; o_irq = 0; o_rdata = 0.
REQ-030 Reset asserted mid-SETTLE SHALL discard the candidate; after release, a held nonzero input SHALL be re-debounced from IDLE and flagged as a change.

Verification
REQ-031 Reset then i_io_sw=32'h0000_00FF held -> o_sw_stable = 32'hFF exactly 18 cycles after the change edge (DB_CYCLES=16); STATUS reads 32'hFF.
REQ-032 Bounce: toggle bit 0 every 5 cycles for 40 cycles, then hold 1 -> o_sw_stable[0] stays 0 until 18 cycles after the last toggle, then becomes 1; no intermediate update.
REQ-033 Glitch: 3-cycle pulse 0 -> 32'h10 -> 0 -> SW stays 0, STATUS stays 0, FSM returns to IDLE.
REQ-034 MASK=32'h1, bit 0 change accepted -> o_irq=1; write STATUS 32'h1 -> o_irq=0 next cycle; a change on bit 4 alone keeps o_irq=0.
REQ-035 W1C of 32'h2 on the same edge that bit 1 is re-flagged -> STATUS[1] remains 1.
REQ-036 Assert i_rst_n low at cnt=10 with i_io_sw=32'hA5, then release -> all outputs 0 during reset; SW = 32'hA5 18 cycles after release; STATUS = 32'hA5.

Source files
------------

// File: rtl/sw_input_periph_if.sv
// LSU-side register bus of the switch input peripheral.
// The slave modport is the peripheral view; the master modport is the LSU or bench view.
interface sw_input_periph_if;
    logic        i_sel;
    logic        i_we;
    logic [3:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (output i_sel, output i_we, output i_addr, output i_wdata, input o_rdata);
    modport slave  (input i_sel, input i_we, input i_addr, input i_wdata, output o_rdata);
endinterface

// File: rtl/sw_input_periph.sv
// Board switch input peripheral: synchronises and debounces a 32-bit switch vector,
// latches per-bit change flags and raises a maskable level interrupt.
module sw_input_periph #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_io_sw,
    sw_input_periph_if.slave bus,
    output logic             o_irq,
    output logic [31:0]      o_sw_stable
);

    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_SETTLE  = 1'b1;
    localparam logic [1:0]       REG_SW     = 2'd0;
    localparam logic [1:0]       REG_STATUS = 2'd1;
    localparam logic [1:0]       REG_MASK   = 2'd2;
    localparam logic [1:0]       REG_INFO   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DB_CYCLES - 32'd1);
    localparam logic [15:0]      DB_INFO    = 16'(DB_CYCLES);

    logic [31:0]      sync1_q, sync2_q;
    logic [31:0]      cand_q, cand_d;
    logic [31:0]      stable_q, stable_d;
    logic [31:0]      status_q, status_d;
    logic [31:0]      mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic             accept_s;
    logic             wr_s;
    logic [1:0]       reg_sel_s;
    logic [31:0]      rdata_s;
    logic             unused_addr_s;

    assign wr_s          = bus.i_sel & bus.i_we;
    assign reg_sel_s     = bus.i_addr[3:2];
    assign unused_addr_s = ^bus.i_addr[1:0];

    // Debounce FSM: a candidate must survive DB_CYCLES consecutive samples to become stable
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q != stable_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = CNT_ONE;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = cand_q;
                    accept_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status W1C and mask writes; change flags are ORed in last so a same-edge set wins
    always_comb begin
        status_d = status_q;
        mask_d   = mask_q;
        if (wr_s && (reg_sel_s == REG_STATUS)) begin
            status_d = status_q & ~bus.i_wdata;
        end else begin
            status_d = status_q;
        end
        if (accept_s) begin
            status_d = status_d | (stable_q ^ cand_q);
        end else begin
            status_d = status_d;
        end
        if (wr_s && (reg_sel_s == REG_MASK)) begin
            mask_d = bus.i_wdata;
        end else begin
            mask_d = mask_q;
        end
    end

    // Read mux: side-effect free, forced to zero outside a selected read and during reset
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (i_rst_n && bus.i_sel && !bus.i_we) begin
            case (reg_sel_s)
                REG_SW:     rdata_s = stable_q;
                REG_STATUS: rdata_s = status_q;
                REG_MASK:   rdata_s = mask_q;
                REG_INFO:   rdata_s = {state_q, 15'h0000, DB_INFO};
                default:    rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // All state: synchroniser chain, debounce FSM and software-visible registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 32'h0000_0000;
            sync2_q  <= 32'h0000_0000;
            cand_q   <= 32'h0000_0000;
            stable_q <= 32'h0000_0000;
            status_q <= 32'h0000_0000;
            mask_q   <= 32'h0000_0000;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
        end else begin
            sync1_q  <= i_io_sw;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign bus.o_rdata = rdata_s;
    assign o_sw_stable = stable_q;
    assign o_irq       = |(status_q & mask_q);

endmodule

// File: tb/tb_sw_input_periph.sv
// Scoreboard bench for sw_input_periph: a sample-window reference model predicts accepted
// switch values, flags and register reads; a negedge monitor pops and compares them.
module tb_sw_input_periph;

    localparam int DB = 16;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } sw_ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_sw = 32'h0;
    logic        irq;
    logic [31:0] sw_stable;

    sw_input_periph_if bus_if();

    sw_input_periph #(.DB_CYCLES(DB), .CNT_W(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_io_sw    (io_sw),
        .bus        (bus_if),
        .o_irq      (irq),
        .o_sw_stable(sw_stable)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_stable = 32'h0;
    logic [31:0] m_status = 32'h0;
    logic [31:0] m_mask   = 32'h0;
    bit          m_pending = 1'b0;
    int          cyc = 0;
    logic [31:0] pipe[$];
    logic [31:0] win[$];
    sw_ev_t      sw_q[$];
    logic [31:0] rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit win_settled();
        if (win.size() < DB) return 1'b0;
        foreach (win[i]) if (win[i] !== win[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        logic [15:0] db16;
        db16 = 16'(DB);
        case (a[3:2])
            2'd0:    return m_stable;
            2'd1:    return m_status;
            2'd2:    return m_mask;
            default: return {m_pending, 15'h0, db16};
        endcase
    endfunction

    // Reference model: an input reaches the debouncer two edges later; a settle window
    // opens when that sample differs from the accepted value and accepts once the last
    // DB samples of the window agree.
    initial begin
        logic [31:0] s;
        logic [31:0] flags;
        pipe = '{32'h0, 32'h0};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_stable = 32'h0; m_status = 32'h0; m_mask = 32'h0; m_pending = 1'b0;
                pipe = '{32'h0, 32'h0};
                win.delete();
            end else begin
                cyc++;
                s = pipe.pop_front();
                pipe.push_back(io_sw);
                flags = 32'h0;
                if (!m_pending) begin
                    if (s != m_stable) begin
                        m_pending = 1'b1;
                        win.delete();
                        win.push_back(s);
                    end
                end else begin
                    win.push_back(s);
                    if (win.size() > DB) void'(win.pop_front());
                    if (win_settled()) begin
                        flags = m_stable ^ s;
                        if (s != m_stable) sw_q.push_back('{val: s, cyc: cyc});
                        m_stable  = s;
                        m_pending = 1'b0;
                        win.delete();
                    end
                end
                if (bus_if.i_sel && bus_if.i_we) begin
                    case (bus_if.i_addr[3:2])
                        2'd1:    m_status = m_status & ~bus_if.i_wdata;
                        2'd2:    m_mask = bus_if.i_wdata;
                        default: ;
                    endcase
                end
                m_status = m_status | flags;
            end
        end
    end

    // Monitor: compares DUT outputs 2 time units after each falling edge
    initial begin
        logic [31:0] prev;
        sw_ev_t      e;
        prev = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("reset_sw", sw_stable, 32'h0);
                check("reset_irq", {31'h0, irq}, 32'h0);
                check("reset_rdata", bus_if.o_rdata, 32'h0);
                prev = 32'h0;
            end else begin
                if (sw_stable !== prev) begin
                    if (sw_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL sw_unexpected: got %h expected %h at cycle %0d", sw_stable, prev, cyc);
                    end else begin
                        e = sw_q.pop_front();
                        check("sw_value", sw_stable, e.val);
                        check("sw_cycle", 32'(cyc), 32'(e.cyc));
                    end
                    prev = sw_stable;
                end
                if (sw_q.size() > 0 && sw_q[0].cyc < cyc) begin
                    e = sw_q.pop_front();
                    vectors++; miscompares++;
                    $display("FAIL sw_missed: got %h expected %h by cycle %0d", sw_stable, e.val, e.cyc);
                end
                check("irq", {31'h0, irq}, {31'h0, |(m_status & m_mask)});
                if (bus_if.i_sel && !bus_if.i_we) begin
                    if (rd_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL rd_unexpected: got %h expected no read", bus_if.o_rdata);
                    end else begin
                        check("rdata", bus_if.o_rdata, rd_q.pop_front());
                    end
                end else begin
                    check("rdata_idle", bus_if.o_rdata, 32'h0);
                end
            end
        end
    end

    task automatic bus_read(input logic [3:0] a);
        @(negedge clk);
        bus_if.i_sel = 1'b1; bus_if.i_we = 1'b0; bus_if.i_addr = a;
        rd_q.push_back(exp_read(a));
        @(negedge clk);
        bus_if.i_sel = 1'b0;
    endtask

    task automatic bus_read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus_if.i_sel = 1'b1; bus_if.i_we = 1'b0; bus_if.i_addr = a;
        rd_q.push_back(exp_read(a));
        #3;
        check(name, bus_if.o_rdata, exp);
        @(negedge clk);
        bus_if.i_sel = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.i_sel = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = a; bus_if.i_wdata = d;
        @(negedge clk);
        bus_if.i_sel = 1'b0; bus_if.i_we = 1'b0;
    endtask

    task automatic expect_latency(input string name, input logic [31:0] bits, input logic [31:0] old_v,
                                  input logic [31:0] new_v);
        repeat (17) @(posedge clk);
        #1 check({name, "_17"}, sw_stable & bits, old_v);
        @(posedge clk);
        #1 check({name, "_18"}, sw_stable & bits, new_v);
    endtask

    initial begin
        int r;
        bus_if.i_sel = 1'b0; bus_if.i_we = 1'b0; bus_if.i_addr = 4'h0; bus_if.i_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        bus_read_chk("rst_sw", 4'h0, 32'h0);
        bus_read_chk("rst_status", 4'h4, 32'h0);
        bus_read_chk("rst_mask", 4'h8, 32'h0);
        bus_read_chk("rst_info", 4'hC, 32'h0000_0010);

        // basic acceptance latency
        @(negedge clk) io_sw = 32'h0000_00FF;
        expect_latency("lat_ff", 32'hFFFF_FFFF, 32'h0, 32'h0000_00FF);
        bus_read_chk("status_ff", 4'h4, 32'h0000_00FF);
        @(negedge clk) io_sw = 32'h0;
        repeat (25) @(negedge clk);
        bus_write(4'h4, 32'hFFFF_FFFF);

        // bounce on bit 0, ending high
        for (int i = 0; i < 9; i++) begin
            @(negedge clk) io_sw[0] = ~io_sw[0];
            if (i < 8) repeat (4) @(negedge clk);
        end
        expect_latency("bounce", 32'h1, 32'h0, 32'h1);
        bus_write(4'h4, 32'hFFFF_FFFF);

        // 3-cycle glitch on bit 4
        @(negedge clk) io_sw = 32'h0000_0011;
        repeat (3) @(negedge clk);
        io_sw = 32'h0000_0001;
        bus_read(4'hC);
        repeat (25) @(negedge clk);
        bus_read_chk("glitch_sw", 4'h0, 32'h0000_0001);
        bus_read_chk("glitch_status", 4'h4, 32'h0);
        bus_read_chk("glitch_info", 4'hC, 32'h0000_0010);

        // interrupt masking and W1C
        bus_write(4'h8, 32'h1);
        @(negedge clk) io_sw = 32'h0;
        repeat (20) @(negedge clk);
        #2 check("irq_set", {31'h0, irq}, 32'h1);
        bus_write(4'h4, 32'h1);
        #2 check("irq_clr", {31'h0, irq}, 32'h0);
        @(negedge clk) io_sw = 32'h0000_0010;
        repeat (20) @(negedge clk);
        #2 check("irq_bit4", {31'h0, irq}, 32'h0);
        bus_read_chk("status_bit4", 4'h4, 32'h0000_0010);
        bus_write(4'h4, 32'hFFFF_FFFF);

        // W1C on the same edge a flag is set
        @(negedge clk) io_sw = 32'h0000_0012;
        repeat (17) @(negedge clk);
        bus_if.i_sel = 1'b1; bus_if.i_we = 1'b1; bus_if.i_addr = 4'h4; bus_if.i_wdata = 32'h2;
        @(negedge clk);
        bus_if.i_sel = 1'b0; bus_if.i_we = 1'b0;
        bus_read_chk("set_wins", 4'h4, 32'h0000_0002);
        bus_write(4'h4, 32'hFFFF_FFFF);

        // reset in the middle of a settle window
        @(negedge clk) io_sw = 32'h0000_00A5;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #2 check("rst_mid_sw", sw_stable, 32'h0);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_latency("rst_a5", 32'hFFFF_FFFF, 32'h0, 32'h0000_00A5);
        bus_read_chk("rst_a5_status", 4'h4, 32'h0000_00A5);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                @(negedge clk);
                if (r == 0) io_sw = $urandom;
                else io_sw = io_sw ^ (32'h1 << $urandom_range(0, 31));
            end else if (r < 6) begin
                bus_read(4'($urandom_range(0, 15)));
            end else if (r < 8) begin
                bus_write(4'($urandom_range(0, 15)), $urandom);
            end else begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
        end
        repeat (40) @(negedge clk);
        #3;
        check("sw_queue_empty", 32'(sw_q.size()), 32'h0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
